// File: rtl/game_pkg.sv
// game_pkg: shared state type, width helpers, LFSR taps and default durations for game_sequencer.
package game_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SHOW, S_ARM, S_WIN, S_LOSE} state_t;
  localparam int DEF_CODE_W = 5;
  localparam int DEF_SHOW_S = 5;
  localparam int DEF_LIMIT_S = 20;
  localparam int DEF_LEVEL_STEP_S = 2;
  localparam int DEF_MIN_S = 6;
  localparam int DEF_PENALTY_S = 3;
  localparam int DEF_HOLD_S = 3;
  localparam int DEF_MAX_LEVEL = 7;
  function automatic int sec_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 1 ? 1 : $clog2(m + 1);
  endfunction
  function automatic int lvl_width(input int m);
    return m < 1 ? 1 : $clog2(m + 1);
  endfunction
  // Arm window for a level, clamped to the floor without ever going negative.
  function automatic int arm_secs(input int lvl, input int limit, input int step, input int floor_s);
    int red;
    red = lvl * step;
    return (red >= limit || limit - red < floor_s) ? floor_s : limit - red;
  endfunction
  // Fibonacci feedback masks of primitive polynomials, bit n-1 set for tap n.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      2: return 16'h0003;
      3: return 16'h0006;
      4: return 16'h000C;
      5: return 16'h0014;
      6: return 16'h0030;
      7: return 16'h0060;
      8: return 16'h00B8;
      9: return 16'h0110;
      10: return 16'h0240;
      11: return 16'h0500;
      12: return 16'h0829;
      13: return 16'h100D;
      14: return 16'h2015;
      15: return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction
endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: free-running maximal-length Fibonacci LFSR, never reaches zero from a nonzero seed.
module game_lfsr import game_pkg::*; #(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] SEED = 'h1
) (
  input  logic             clk,
  input  logic             rst_p,
  output logic [WIDTH-1:0] value
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst_p) r_q <= SEED;
    else r_q <= {r_q[WIDTH-2:0], ^(r_q & TAPS)};
  end
  assign value = r_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: show/arm/result flow controller with countdown, penalty and difficulty levels.
// Define GAME_SEQ_AUTO_RESTART_EN to start the next round directly when the result hold expires.
module game_sequencer import game_pkg::*; #(
  parameter int CODE_W = DEF_CODE_W,
  parameter int SHOW_S = DEF_SHOW_S,
  parameter int LIMIT_S = DEF_LIMIT_S,
  parameter int LEVEL_STEP_S = DEF_LEVEL_STEP_S,
  parameter int MIN_S = DEF_MIN_S,
  parameter int PENALTY_S = DEF_PENALTY_S,
  parameter int HOLD_S = DEF_HOLD_S,
  parameter int MAX_LEVEL = DEF_MAX_LEVEL,
  parameter logic [CODE_W-1:0] SEED = 'h1,
  localparam int SEC_W = sec_width(SHOW_S, LIMIT_S, HOLD_S),
  localparam int LVL_W = lvl_width(MAX_LEVEL)
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              enable,
  input  logic              start_btn,
  input  logic              tick,
  input  logic              entry_valid,
  input  logic              entry_ok,
  output logic [CODE_W-1:0] code,
  output logic              show_en,
  output logic              bomb_en,
  output logic              input_en,
  output logic              timer_en,
  output logic [SEC_W-1:0]  secs_left,
  output logic [LVL_W-1:0]  level,
  output logic              success,
  output logic              fail,
  output logic              sub_rst
);
  localparam logic [SEC_W-1:0] SHOW_T = SEC_W'(SHOW_S);
  localparam logic [SEC_W-1:0] HOLD_T = SEC_W'(HOLD_S);
  localparam logic [SEC_W-1:0] ONE_S = SEC_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
  state_t r_state, w_next;
  logic [SEC_W-1:0] r_secs, w_secs, w_arm;
  logic [LVL_W-1:0] r_level, w_level;
  logic [CODE_W-1:0] r_code, w_lfsr;
  logic r_sub_rst, r_start_q, r_en_q, w_load, w_start_edge;
  int w_dec;
  game_lfsr #(.WIDTH(CODE_W), .SEED(SEED)) u_lfsr (.clk(clk), .rst_p(rst_p), .value(w_lfsr));
  assign w_start_edge = start_btn & ~r_start_q;
  assign w_arm = SEC_W'(arm_secs(int'(r_level), LIMIT_S, LEVEL_STEP_S, MIN_S));
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_state <= S_IDLE;
      r_secs <= '0;
      r_level <= '0;
      r_code <= '0;
      r_sub_rst <= 1'b0;
      r_start_q <= 1'b0;
      r_en_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_secs <= w_secs;
      r_level <= w_level;
      r_code <= w_load ? w_lfsr : r_code;
      r_sub_rst <= w_load | (r_en_q & ~enable);
      r_start_q <= start_btn;
      r_en_q <= enable;
    end
  end
  // Correct entry wins over a same-cycle tick; a wrong entry stacks with it.
  always_comb begin
    w_next = r_state;
    w_secs = r_secs;
    w_level = r_level;
    w_load = 1'b0;
    w_dec = (entry_valid ? PENALTY_S : 0) + (tick ? 1 : 0);
    if (!enable) begin
      w_next = S_IDLE;
      w_secs = '0;
      w_level = '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_edge) begin
          w_next = S_SHOW;
          w_secs = SHOW_T;
          w_load = 1'b1;
        end
        S_SHOW: if (tick) begin
          w_next = r_secs == ONE_S ? S_ARM : S_SHOW;
          w_secs = r_secs == ONE_S ? w_arm : r_secs - ONE_S;
        end
        S_ARM: if (entry_valid && entry_ok) begin
          w_next = S_WIN;
          w_secs = HOLD_T;
          w_level = r_level == LVL_MAX ? r_level : r_level + LVL_W'(1);
        end else if (int'(r_secs) <= w_dec) begin
          w_next = S_LOSE;
          w_secs = HOLD_T;
        end else w_secs = SEC_W'(int'(r_secs) - w_dec);
        default: if (tick) begin
          if (r_secs == ONE_S) begin
            w_level = r_state == S_LOSE ? '0 : r_level;
`ifdef GAME_SEQ_AUTO_RESTART_EN
            w_next = S_SHOW;
            w_secs = SHOW_T;
            w_load = 1'b1;
`else
            w_next = S_IDLE;
            w_secs = '0;
`endif
          end else w_secs = r_secs - ONE_S;
        end
      endcase
    end
  end
  always_comb begin
    show_en = r_state == S_SHOW;
    bomb_en = r_state == S_SHOW || r_state == S_ARM;
    input_en = r_state == S_ARM;
    timer_en = r_state == S_ARM;
    success = r_state == S_WIN;
    fail = r_state == S_LOSE;
  end
  assign code = r_code;
  assign secs_left = r_secs;
  assign level = r_level;
  assign sub_rst = r_sub_rst;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed test-plan scenarios then random play, checked each cycle against a behavioural model.
module tb_game_sequencer;
  import game_pkg::*;
  localparam int SEC_W = sec_width(DEF_SHOW_S, DEF_LIMIT_S, DEF_HOLD_S);
  localparam int LVL_W = lvl_width(DEF_MAX_LEVEL);
  localparam int P_IDLE = 0, P_SHOW = 1, P_ARM = 2, P_WIN = 3, P_LOSE = 4;
  logic clk = 0, rst_p = 1, enable = 0, start_btn = 0, tick = 0, entry_valid = 0, entry_ok = 0;
  logic [DEF_CODE_W-1:0] code, prev_code;
  logic show_en, bomb_en, input_en, timer_en, success, fail, sub_rst;
  logic [SEC_W-1:0] secs_left;
  logic [LVL_W-1:0] level;
  int n_checks = 0, n_fail = 0;
  bit chk = 0;
  int m_phase = P_IDLE, m_secs = 0, m_lvl = 0;
  bit m_srst = 0, m_pstart = 0, m_pen = 0, m_started = 0, m_loaded = 0;

  game_sequencer dut (
    .clk(clk), .rst_p(rst_p), .enable(enable), .start_btn(start_btn), .tick(tick),
    .entry_valid(entry_valid), .entry_ok(entry_ok), .code(code), .show_en(show_en),
    .bomb_en(bomb_en), .input_en(input_en), .timer_en(timer_en), .secs_left(secs_left),
    .level(level), .success(success), .fail(fail), .sub_rst(sub_rst)
  );

  always #5 clk = ~clk;

  function automatic int arm_time(input int lvl);
    int t;
    t = DEF_LIMIT_S - lvl * DEF_LEVEL_STEP_S;
    return t < DEF_MIN_S ? DEF_MIN_S : t;
  endfunction

  function automatic void new_round();
    m_phase = P_SHOW;
    m_secs = DEF_SHOW_S;
    m_srst = 1;
    m_started = 1;
    m_loaded = 1;
  endfunction

  // Reference game rules, advanced once per clock with the inputs the DUT sees.
  always @(posedge clk) begin
    m_loaded = 0;
    if (rst_p) begin
      m_phase = P_IDLE; m_secs = 0; m_lvl = 0; m_srst = 0;
      m_pstart = 0; m_pen = 0; m_started = 0;
    end else begin
      m_srst = m_pen && !enable;
      if (!enable) begin
        m_phase = P_IDLE; m_secs = 0; m_lvl = 0;
      end else if (m_phase == P_IDLE) begin
        if (start_btn && !m_pstart) new_round();
      end else if (m_phase == P_SHOW) begin
        m_secs -= int'(tick);
        if (m_secs == 0) begin m_phase = P_ARM; m_secs = arm_time(m_lvl); end
      end else if (m_phase == P_ARM) begin
        if (entry_valid && entry_ok) begin
          m_phase = P_WIN; m_secs = DEF_HOLD_S;
          m_lvl = m_lvl + 1 > DEF_MAX_LEVEL ? DEF_MAX_LEVEL : m_lvl + 1;
        end else begin
          m_secs -= (entry_valid ? DEF_PENALTY_S : 0) + int'(tick);
          if (m_secs <= 0) begin m_phase = P_LOSE; m_secs = DEF_HOLD_S; end
        end
      end else begin
        m_secs -= int'(tick);
        if (m_secs == 0) begin
          if (m_phase == P_LOSE) m_lvl = 0;
`ifdef GAME_SEQ_AUTO_RESTART_EN
          new_round();
`else
          m_phase = P_IDLE;
`endif
        end
      end
      m_pstart = start_btn;
      m_pen = enable;
    end
  end

  always @(negedge clk) begin
    logic [6+SEC_W+LVL_W:0] act, exp;
    if (chk) begin
      act = {show_en, bomb_en, input_en, timer_en, success, fail, sub_rst, secs_left, level};
      exp = {m_phase == P_SHOW, m_phase == P_SHOW || m_phase == P_ARM, m_phase == P_ARM,
             m_phase == P_ARM, m_phase == P_WIN, m_phase == P_LOSE, m_srst,
             SEC_W'(m_secs), LVL_W'(m_lvl)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs @%0t: got %h expected %h (phase %0d)", $time, act, exp, m_phase);
      end
      n_checks++;
      if (m_started ? (code === '0 || $isunknown(code)) : (code !== '0)) begin
        n_fail++;
        $display("FAIL code_zero @%0t: got %h, started=%0d", $time, code, m_started);
      end
      if (m_started && !m_loaded) begin
        n_checks++;
        if (code !== prev_code) begin
          n_fail++;
          $display("FAIL code_stable @%0t: got %h required %h", $time, code, prev_code);
        end
      end
      prev_code = code;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic t, input logic v, input logic ok);
    tick = t; entry_valid = v; entry_ok = ok;
    @(negedge clk);
    tick = 0; entry_valid = 0; entry_ok = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0);
  endtask

  task automatic begin_round();
`ifndef GAME_SEQ_AUTO_RESTART_EN
    start_btn = 1;
    cycle(0, 0, 0);
    start_btn = 0;
`endif
  endtask

  initial begin
    @(negedge clk);
    chk = 1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {show_en, bomb_en, input_en, timer_en, success, fail, sub_rst}, 0);
    check("reset_code_level", {code, level}, 0);
    rst_p = 0;
    enable = 1;
    cycle(0, 0, 0);
    start_btn = 1;
    cycle(1, 0, 0);
    start_btn = 0;
    check("show_entry_sub_rst", sub_rst, 1);
    check("show_entry_secs", secs_left, 5);
    cycle(0, 0, 0);
    check("sub_rst_single", sub_rst, 0);
    ticks(4);
    check("show_last_sec", {show_en, secs_left}, {1'b1, 5'd1});
    ticks(1);
    check("arm_entry", {input_en, timer_en, show_en, secs_left}, {3'b110, 5'd20});
    ticks(10);
    check("arm_at_10", secs_left, 10);
    cycle(0, 1, 0);
    check("wrong_entry_penalty", secs_left, 7);
    ticks(3);
    cycle(1, 1, 0);
    check("wrong_plus_tick_lose", {fail, secs_left}, {1'b1, 5'd3});
    ticks(2);
    check("lose_hold", {fail, secs_left}, {1'b1, 5'd1});
    ticks(1);
`ifdef GAME_SEQ_AUTO_RESTART_EN
    check("auto_restart_show", {show_en, sub_rst, level}, {2'b11, 3'd0});
    check("auto_restart_code_nonzero", code != 0, 1);
`else
    check("lose_exit_idle", {fail, bomb_en, level}, 0);
`endif
    begin_round();
    ticks(5);
    check("arm_level0", secs_left, 20);
    ticks(19);
    cycle(1, 1, 1);
    check("win_coincident_tick", {success, level, secs_left}, {1'b1, 3'd1, 5'd3});
    ticks(3);
    check("win_exit_level_kept", level, 1);
    begin_round();
    ticks(5);
    check("arm_level1", secs_left, 18);
    start_btn = 1;
    cycle(0, 0, 0);
    start_btn = 0;
    check("start_ignored_in_arm", {input_en, sub_rst, secs_left}, {2'b10, 5'd18});
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1);
      ticks(3);
      begin_round();
      ticks(5);
    end
    check("level_saturated", level, 7);
    check("arm_floor", secs_left, 6);
    ticks(2);
    enable = 0;
    cycle(0, 0, 0);
    check("enable_drop", {show_en, bomb_en, input_en, timer_en, level, sub_rst}, 8'd1);
    cycle(0, 0, 0);
    check("enable_drop_pulse_once", sub_rst, 0);
    cycle(0, 1, 1);
    check("entry_ignored_idle", success, 0);
    enable = 1;
    cycle(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      rst_p = $urandom_range(0, 399) == 0;
      enable = $urandom_range(0, 149) != 0;
      start_btn = $urandom_range(0, 5) == 0;
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
    end
    chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
